// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared fetch-stage constants: boot/exception vectors,
//                sequencer state codes, exception cause codes and a small
//                alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Boot address; the PC register resets to the same value.
    localparam logic [31:0] c_RESET_VEC   = 32'h0040_0000;
    // Exception handler entry address.
    localparam logic [31:0] c_EXC_VEC     = 32'h8000_0180;

    // Sequencer state codes (also visible on the debug port).
    localparam logic [1:0]  c_ST_BOOT     = 2'd0;
    localparam logic [1:0]  c_ST_RUN      = 2'd1;
    localparam logic [1:0]  c_ST_DRAIN    = 2'd2;
    localparam logic [1:0]  c_ST_VECTOR   = 2'd3;

    // Exception cause codes.
    localparam logic [1:0]  c_CAUSE_NONE  = 2'b00;
    localparam logic [1:0]  c_CAUSE_EXT   = 2'b01;
    localparam logic [1:0]  c_CAUSE_BR    = 2'b10;
    localparam logic [1:0]  c_CAUSE_JMP   = 2'b11;

    // A control-flow target is only legal on a word boundary.
    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_mux
//  Description : Fixed-priority next-PC selector for the RUN state. Produces
//                the PC register input, its hold control and the IF/ID
//                flush strobes from already-decoded requests.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next_mux (
    input  logic        i_trap,
    input  logic        i_eret,
    input  logic        i_br,
    input  logic        i_jmp,
    input  logic        i_stall,
    input  logic [31:0] i_pc_cur,
    input  logic [31:0] i_epc,
    input  logic [31:0] i_br_target,
    input  logic [31:0] i_jmp_target,
    output logic [31:0] o_next_pc,
    output logic        o_pc_hold,
    output logic        o_flush_if,
    output logic        o_flush_id
);

    // Priority select: trap > eret > branch > jump > stall > sequential.
    // Redirects sit above stall so a stalled ID instruction gets squashed.
    always_comb begin
        o_next_pc  = i_pc_cur + 32'd4;   // wraps modulo 2^32, no trap
        o_pc_hold  = 1'b0;
        o_flush_if = 1'b0;
        o_flush_id = 1'b0;
        if (i_trap) begin
            o_next_pc  = i_pc_cur;
            o_pc_hold  = 1'b1;
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
        end else if (i_eret) begin
            o_next_pc  = i_epc;
            o_flush_if = 1'b1;
        end else if (i_br) begin
            o_next_pc  = i_br_target;
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
        end else if (i_jmp) begin
            o_next_pc  = i_jmp_target;
            o_flush_if = 1'b1;
        end else if (i_stall) begin
            o_next_pc  = i_pc_cur;
            o_pc_hold  = 1'b1;
        end
    end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_ctrl
//  Description : Next-PC sequencing controller for the fetch stage. Runs a
//                BOOT/RUN/DRAIN/VECTOR sequencer, captures EPC and cause on
//                exception entry and drives the PC register input, hold and
//                IF/ID flush strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_seq_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC    = c_RESET_VEC,
    parameter logic [31:0] EXC_VEC      = c_EXC_VEC,
    parameter int unsigned DRAIN_CYCLES = 2          // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        stall_req,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic        eret_valid,
    output logic [31:0] next_pc,
    output logic        pc_hold,
    output logic        flush_if,
    output logic        flush_id,
    output logic        exc_taken,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic [1:0]  state
);

    // Drain counter counts down to zero, so it is loaded with one less than
    // the number of hold cycles wanted.
    localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [1:0]  r_state,     w_state_nxt;
    logic [3:0]  r_cnt,       w_cnt_nxt;
    logic [31:0] r_epc,       w_epc_nxt;
    logic [1:0]  r_cause,     w_cause_nxt;
    logic        r_exc_taken, w_exc_taken_nxt;

    logic        w_br_mis;
    logic        w_jmp_mis;
    logic        w_trap;
    logic [31:0] w_mux_next_pc;
    logic        w_mux_pc_hold;
    logic        w_mux_flush_if;
    logic        w_mux_flush_id;

    // A misaligned redirect target traps instead of being followed.
    assign w_br_mis  = br_valid  & misaligned(br_target);
    assign w_jmp_mis = jmp_valid & misaligned(jmp_target);
    assign w_trap    = exc_req | w_br_mis | w_jmp_mis;

    pc_next_mux u_pc_next_mux (
        .i_trap       (w_trap),
        .i_eret       (eret_valid),
        .i_br         (br_valid),
        .i_jmp        (jmp_valid),
        .i_stall      (stall_req),
        .i_pc_cur     (pc_cur),
        .i_epc        (r_epc),
        .i_br_target  (br_target),
        .i_jmp_target (jmp_target),
        .o_next_pc    (w_mux_next_pc),
        .o_pc_hold    (w_mux_pc_hold),
        .o_flush_if   (w_mux_flush_if),
        .o_flush_id   (w_mux_flush_id)
    );

    // Per-state output steering; only RUN consults the request mux.
    always_comb begin
        next_pc  = RESET_VEC;
        pc_hold  = 1'b1;
        flush_if = 1'b1;
        flush_id = 1'b1;
        case (r_state)
            c_ST_RUN: begin
                next_pc  = w_mux_next_pc;
                pc_hold  = w_mux_pc_hold;
                flush_if = w_mux_flush_if;
                flush_id = w_mux_flush_id;
            end
            c_ST_DRAIN: begin
                next_pc  = pc_cur;
            end
            c_ST_VECTOR: begin
                next_pc  = EXC_VEC;
                pc_hold  = 1'b0;
                flush_id = 1'b0;
            end
            default: begin
                next_pc  = RESET_VEC;
            end
        endcase
    end

    // Next-state logic: sequencer, drain counter and EPC/cause capture.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_epc_nxt   = r_epc;
        w_cause_nxt = r_cause;
        case (r_state)
            c_ST_BOOT: begin
                w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_trap) begin
                    w_epc_nxt   = pc_cur;
                    w_cnt_nxt   = c_DRAIN_LOAD;
                    w_state_nxt = c_ST_DRAIN;
                    if (exc_req) begin
                        w_cause_nxt = c_CAUSE_EXT;
                    end else if (w_br_mis) begin
                        w_cause_nxt = c_CAUSE_BR;
                    end else begin
                        w_cause_nxt = c_CAUSE_JMP;
                    end
                end else if (eret_valid) begin
                    w_cause_nxt = c_CAUSE_NONE;
                end
            end
            c_ST_DRAIN: begin
                // Every request input is ignored while draining.
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ST_VECTOR;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
        w_exc_taken_nxt = (w_state_nxt == c_ST_VECTOR);
    end

    // State registers; reset acts immediately, even mid-drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_BOOT;
            r_cnt       <= 4'd0;
            r_epc       <= RESET_VEC;
            r_cause     <= c_CAUSE_NONE;
            r_exc_taken <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_epc       <= w_epc_nxt;
            r_cause     <= w_cause_nxt;
            r_exc_taken <= w_exc_taken_nxt;
        end
    end

    assign exc_taken = r_exc_taken;
    assign epc       = r_epc;
    assign cause     = r_cause;
    assign state     = r_state;

endmodule : pc_seq_ctrl
`default_nettype wire

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Next-PC sequencing controller for the fetch stage. It selects the value driven into the PC register's `PC_i` input, asserts its `PC_Hold`, and generates IF/ID flush strobes. Selection is a fixed priority among exception entry, exception return, branch, jump, hazard stall and sequential increment. A small FSM handles post-reset boot and the exception drain/vector sequence, capturing EPC and cause.

## Interface
- `RESET_VEC`, 32'h00400000, boot address; must equal the PC register reset value
- `EXC_VEC`, 32'h80000180, exception handler entry address
- `DRAIN_CYCLES`, 2, hold cycles before vectoring (range 1..15)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pc_cur`  in  32  current PC (PC register output)
- `stall_req`  in  1  hazard-unit stall request
- `br_valid`  in  1  taken branch resolved this cycle
- `br_target`  in  32  branch target
- `jmp_valid`  in  1  jump decoded this cycle
- `jmp_target`  in  32  jump target
- `exc_req`  in  1  external exception/interrupt request (level)
- `eret_valid`  in  1  exception-return instruction decoded
- `next_pc`  out  32  value for PC register `PC_i`
- `pc_hold`  out  1  drives PC register `PC_Hold`
- `flush_if`, `flush_id`  out  1 each  squash IF / ID stage contents
- `exc_taken`  out  1  one-cycle pulse on vector redirect
- `epc`  out  32  captured exception PC
- `cause`  out  2  00 none, 01 external, 10 misaligned branch, 11 misaligned jump
- `state`  out  2  FSM state, for debug

## Operation
- States: BOOT=0, RUN=1, DRAIN=2, VECTOR=3.
- Reset values: state=BOOT, drain counter=0, epc=RESET_VEC, cause=00, exc_taken=0.
- BOOT, one cycle:
  - Outputs: next_pc=RESET_VEC, pc_hold=1, flush_if=1, flush_id=1.
  - Next state: RUN.
- RUN priority, first match wins:
  1. `exc_req`, or `br_valid` with br_target[1:0]≠0, or `jmp_valid` with jmp_target[1:0]≠0:
     - Capture epc=pc_cur. Cause follows the same order: exc_req→01, else branch→10, else jump→11.
     - Outputs: pc_hold=1, flush_if=1, flush_id=1.
     - Load counter=DRAIN_CYCLES-1. Go to DRAIN.
  2. `eret_valid`: next_pc=epc, pc_hold=0, flush_if=1; cause cleared to 00.
  3. `br_valid`: next_pc=br_target, pc_hold=0, flush_if=1, flush_id=1.
  4. `jmp_valid`: next_pc=jmp_target, pc_hold=0, flush_if=1.
  5. `stall_req`: pc_hold=1, next_pc=pc_cur, no flush.
  6. Otherwise: next_pc=pc_cur+4, pc_hold=0.
- Redirects override stall. A simultaneous branch and stall takes the branch; the stalled ID instruction is flushed.
- Increment is modulo 2^32: pc_cur=32'hFFFFFFFC gives next_pc=0. No trap.
- DRAIN:
  - Outputs: pc_hold=1, flush_if=1, flush_id=1.
  - Counter decrements each cycle; at 0, go to VECTOR.
  - All request inputs are ignored, including new `exc_req` and `eret_valid`.
- VECTOR, one cycle:
  - Outputs: next_pc=EXC_VEC, pc_hold=0, exc_taken=1, flush_if=1.
  - Next state: RUN.
- `exc_req` held high after vectoring re-enters DRAIN from RUN. Requesters must drop it on `exc_taken`.
- Reset asserted in any state, mid-drain included, forces BOOT immediately. epc and cause are cleared.

## Timing
- `next_pc`, `pc_hold` and the flushes are combinational from state and inputs. No added latency in RUN.
- `epc`, `cause`, `state` and `exc_taken` are registered: `exc_taken` is high exactly while state=VECTOR.
- Exception latency: request seen in RUN at cycle N → DRAIN for DRAIN_CYCLES cycles → VECTOR at N+DRAIN_CYCLES+1. Redirect is loaded into the PC register at the end of that cycle.
- Outputs are reset values while `reset` is high.

## Structure
- Shared package `cpu_pkg`: state enum, cause codes, RESET_VEC/EXC_VEC constants. The PC register uses the same RESET_VEC.
- One sub-module is natural: `pc_next_mux`, a combinational priority mux producing next_pc, pc_hold and flushes from decoded RUN requests.
- FSM, drain counter and epc/cause registers stay in the top level.

## Test plan
- Reset release → one BOOT cycle with next_pc=0x00400000, pc_hold=1 → RUN with pc_cur=0x00400000 giving next_pc=0x00400004.
- pc_cur=0x00400010, stall_req=1 and br_valid=1 with br_target=0x00400100 → next_pc=0x00400100, pc_hold=0, flush_if=1, flush_id=1.
- exc_req at pc_cur=0x00400020 with DRAIN_CYCLES=2 → epc=0x00400020, cause=01, two DRAIN cycles with pc_hold=1, then VECTOR: next_pc=0x80000180 and a one-cycle exc_taken pulse.
- jmp_valid with jmp_target=0x00400102 → cause=11, epc=pc_cur, DRAIN entered. A later eret_valid → next_pc=epc, cause=00.
- pc_cur=0xFFFFFFFC, no requests → next_pc=0x00000000, no exception.
- Reset pulse during DRAIN → state=BOOT asynchronously, epc=0x00400000, cause=00, exc_taken never asserted.
